disp_conf_packer: RTL and testbench

Packs the decimated `{disp, conf}` sample stream into 32-bit frame-delimited words for the DMA/frame-buffer writer. It sits directly downstream of the disparity-filtering pixel processor's output FIFO and consumes its `disp_conf_out`/`out_valid`/`out_ready` handshake. It can optionally invalidate low-confidence disparities and counts columns and rows to generate start- and end-of-frame markers.

---
 rtl/disp_filter_pkg.sv | 23 ++
 rtl/disp_conf_packer_st_out_reg.sv | 53 +++++
 rtl/disp_conf_packer.sv | 121 ++++++++++++
 tb/tb_disp_conf_packer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/disp_filter_pkg.sv
// Shared types and widths for the disparity-filter output path.
// DISP_BITS : disparity field width (DISP_BITS + 8 <= 16)
// SAMPLE_W  : zero-extended sample width in a packed word
// WORD_W    : packed output word width
package disp_filter_pkg;
  localparam int DISP_BITS = 5;
  localparam int SAMPLE_W  = 16;
  localparam int WORD_W    = 32;

  typedef struct packed {
    logic [DISP_BITS-1:0] disp;
    logic [7:0]           conf;
  } disp_conf_t;

  typedef logic [WORD_W-1:0] packed_word_t;

  // Contents of the output holding stage.
  typedef struct packed {
    packed_word_t data;
    logic         sop;
    logic         eop;
  } out_beat_t;
endpackage

// File: rtl/disp_conf_packer_st_out_reg.sv
// st_out_reg: single-entry ready/valid holding stage carrying {data, sop, eop}.
// Ports:
//   clk, reset          clock, async active-high reset
//   load                write a new beat (caller guarantees stage empty or draining)
//   in_data/sop/eop     beat to load
//   out_ready           downstream accepts when out_valid && out_ready
//   out_data/sop/eop    held beat, stable while out_valid && !out_ready
//   out_valid           stage holds a beat
module st_out_reg
  import disp_filter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_valid
);
  out_beat_t beat_q, beat_d;
  logic      valid_q, valid_d;

  // A load in the same cycle as a drain replaces the old beat without a bubble.
  always_comb begin
    beat_d  = beat_q;
    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
      beat_d  = '{data: in_data, sop: in_sop, eop: in_eop};
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = beat_q.data;
  assign out_sop   = beat_q.sop;
  assign out_eop   = beat_q.eop;
  assign out_valid = valid_q;
endmodule

// File: rtl/disp_conf_packer.sv
// disp_conf_packer: packs {disp, conf} samples pairwise into 32-bit words
// {odd16, even16} with start/end-of-frame markers from column/row counters.
// Optional feature macro: DISP_CONF_PACKER_THRESH_EN -- when defined, the
// disp field of a sample whose conf < conf_thresh is zeroed before packing.
// Ports:
//   clk, reset                  clock, async active-high reset
//   in_data/in_valid/in_ready   sample stream, conf in [7:0]
//   conf_thresh                 confidence threshold (quasi-static)
//   out_data/out_valid/out_ready packed word stream
//   out_sop/out_eop             first/last word of a frame
//   frame_done                  high while the eop word is being accepted
module disp_conf_packer
  import disp_filter_pkg::*;
#(
  parameter int disp_bits        = DISP_BITS,
  parameter int dec_frame_width  = 240,
  parameter int dec_frame_height = 180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [disp_bits+7:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           conf_thresh,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 frame_done
);
  localparam int COL_W = (dec_frame_width  > 1) ? $clog2(dec_frame_width)  : 1;
  localparam int ROW_W = (dec_frame_height > 1) ? $clog2(dec_frame_height) : 1;

  logic                 have_low_q, have_low_d;
  logic [SAMPLE_W-1:0]  low_q, low_d;
  logic                 low_sop_q, low_sop_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;

  logic                 in_fire, col_last, row_last, load;
  logic [7:0]           conf;
  logic [disp_bits-1:0] disp, disp_m;
  logic [SAMPLE_W-1:0]  sample16;
  logic                 st_valid;

  assign conf = in_data[7:0];
  assign disp = in_data[disp_bits+7:8];

`ifdef DISP_CONF_PACKER_THRESH_EN
  assign disp_m = (conf < conf_thresh) ? '0 : disp;
`else
  logic unused_conf_thresh;
  assign unused_conf_thresh = ^conf_thresh;
  assign disp_m = disp;
`endif

  assign sample16 = SAMPLE_W'({disp_m, conf});

  // The even half never waits; the odd half needs room in the output stage.
  assign in_ready = !have_low_q || !st_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign col_last = (col_q == COL_W'(dec_frame_width - 1));
  assign row_last = (row_q == ROW_W'(dec_frame_height - 1));
  assign load     = in_fire && have_low_q;

  always_comb begin
    have_low_d = have_low_q;
    low_d      = low_q;
    low_sop_d  = low_sop_q;
    col_d      = col_q;
    row_d      = row_q;
    if (in_fire) begin
      have_low_d = !have_low_q;
      if (!have_low_q) begin
        low_d     = sample16;
        low_sop_d = (col_q == '0) && (row_q == '0);
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_low_q <= 1'b0;
      low_q      <= '0;
      low_sop_q  <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      have_low_q <= have_low_d;
      low_q      <= low_d;
      low_sop_q  <= low_sop_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  // Even width means the odd half of the last pair sits at col W-1.
  st_out_reg u_out (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .in_data   ({sample16, low_q}),
    .in_sop    (low_sop_q),
    .in_eop    (col_last && row_last),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_valid (st_valid)
  );

  assign out_valid  = st_valid;
  assign frame_done = st_valid && out_ready && out_eop;
endmodule

// File: tb/tb_disp_conf_packer.sv
module tb_disp_conf_packer;
  localparam int W = 4, H = 2, FS = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  conf_thresh = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sop, out_eop, frame_done;

  always #5 clk = ~clk;

  disp_conf_packer #(.disp_bits(5), .dec_frame_width(W), .dec_frame_height(H)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .conf_thresh(conf_thresh), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .frame_done(frame_done)
  );

  typedef struct packed { logic [31:0] data; logic sop; logic eop; } beat_t;

  int    checks = 0, failures = 0;
  beat_t exp_q[$], got_q[$];
  beat_t e;
  int    acc_cnt = 0, sop_cnt = 0, eop_cnt = 0, fd_cnt = 0, pos;
  logic [15:0] low_s, s16;
  logic        low_sop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: masking rule applied to one 13-bit sample, result zero-extended.
  function automatic logic [15:0] mdl(input logic [12:0] s, input logic [7:0] th);
    logic [7:0] c;
    c = s[7:0];
`ifdef DISP_CONF_PACKER_THRESH_EN
    if (c < th) return {8'h00, c};
`else
    if (th == 8'hFF && c == 8'hFF) return {3'b000, s};
`endif
    return {3'b000, s};
  endfunction

  // Scoreboard: samples pair in acceptance order; frame position = index mod W*H.
  always @(negedge clk) begin
    if (reset) begin
      acc_cnt = 0;
      exp_q.delete();
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (acc_cnt % 2 == 0) || (exp_q.size() == 0) || out_ready});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      if (out_valid && out_ready) begin
        got_q.push_back('{out_data, out_sop, out_eop});
        if (out_sop) sop_cnt++;
        if (out_eop) eop_cnt++;
        if (exp_q.size() == 0) chk("unexpected_word", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_sop", {31'd0, out_sop}, {31'd0, e.sop});
          chk("out_eop", {31'd0, out_eop}, {31'd0, e.eop});
          chk("frame_done", {31'd0, frame_done}, {31'd0, e.eop});
        end
      end else begin
        chk("frame_done_idle", {31'd0, frame_done}, 32'd0);
      end
      if (frame_done) fd_cnt++;
      if (in_valid && in_ready) begin
        s16 = mdl(in_data, conf_thresh);
        pos = acc_cnt % FS;
        if (acc_cnt % 2 == 0) begin
          low_s   = s16;
          low_sop = (pos == 0);
        end else begin
          exp_q.push_back('{{s16, low_s}, low_sop, pos == FS - 1});
        end
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [12:0] s);
    bit ok;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = s;
    do begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w1 [4];
    int target, n;
    w1[0] = 32'h01020101; w1[1] = 32'h01040103; w1[2] = 32'h01060105; w1[3] = 32'h01080107;

    // Reset values
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sop", {31'd0, out_sop}, 32'd0);
    chk("rst_out_eop", {31'd0, out_eop}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    tick();

    // Back-to-back frame, out_ready held high
    out_ready = 1'b1;
    got_q.delete(); fd_cnt = 0;
    for (int i = 1; i <= 8; i++) send(13'(32'h0100 + i));
    repeat (3) tick();
    chk("t1_nwords", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) if (i < got_q.size()) chk("t1_word", got_q[i].data, w1[i]);
    if (got_q.size() == 4) begin
      chk("t1_sop", {30'd0, got_q[0].sop, got_q[3].sop}, 32'd2);
      chk("t1_eop", {30'd0, got_q[0].eop, got_q[3].eop}, 32'd1);
    end
    chk("t1_frame_done_cnt", fd_cnt, 32'd1);

    // Backpressure
    got_q.delete();
    out_ready = 1'b0;
    send(13'h0111);
    send(13'h0112);
    send(13'h0113);
    in_valid = 1'b1;
    in_data  = 13'h0114;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_data", out_data, 32'h01120111);
      chk("bp_hold_sop", {31'd0, out_sop}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    send(13'h0114);
    for (int i = 5; i <= 8; i++) send(13'(32'h0110 + i));
    repeat (3) tick();
    chk("bp_nwords", got_q.size(), 32'd4);
    if (got_q.size() == 4) begin
      chk("bp_w0", got_q[0].data, 32'h01120111);
      chk("bp_w1", got_q[1].data, 32'h01140113);
      chk("bp_w3_eop", {31'd0, got_q[3].eop}, 32'd1);
    end

    // Threshold masking
    conf_thresh = 8'h40;
    got_q.delete();
    send(13'h073F);
    send(13'h0740);
    repeat (2) tick();
    chk("th_nwords", got_q.size(), 32'd1);
`ifdef DISP_CONF_PACKER_THRESH_EN
    if (got_q.size() > 0) chk("th_word", got_q[0].data, 32'h0740003F);
`else
    if (got_q.size() > 0) chk("th_word", got_q[0].data, 32'h0740073F);
`endif

    // Reset mid-frame after 3 samples
    send(13'h0555);
    reset = 1'b1;
    tick();
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    conf_thresh = 8'h00;
    got_q.delete(); fd_cnt = 0;
    for (int i = 1; i <= 8; i++) send(13'(32'h0200 + i));
    repeat (3) tick();
    chk("mr_nwords", got_q.size(), 32'd4);
    if (got_q.size() > 0) begin
      chk("mr_first_word", got_q[0].data, 32'h02020201);
      chk("mr_first_sop", {31'd0, got_q[0].sop}, 32'd1);
    end
    chk("mr_frame_done_cnt", fd_cnt, 32'd1);

    // Random valid/ready over 10 frames
    conf_thresh = 8'h40;
    sop_cnt = 0; eop_cnt = 0; fd_cnt = 0;
    target = acc_cnt + 10 * FS;
    n = 0;
    while (acc_cnt < target && n < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 13'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    if (n >= 3000) chk("rand_timeout", 32'd0, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("rand_drained", exp_q.size(), 32'd0);
    chk("rand_sop_cnt", sop_cnt, 32'd10);
    chk("rand_eop_cnt", eop_cnt, 32'd10);
    chk("rand_fd_cnt", fd_cnt, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
